// File: rtl/psg_stereo_core.sv
// SN76489-compatible PSG core: NUM_TONES square channels plus one LFSR noise channel,
// with clock prescaler, stereo pan register and registered saturating left/right mixers.
module psg_stereo_core #(
    parameter int NUM_TONES              = 3,
    parameter int CLOCK_DIV              = 16,
    parameter int FREQUENCY_COUNTER_BITS = 10,
    parameter int LFSR_BITS              = 15,
    parameter int NOISE_TAP              = 1,
    parameter int CHANNEL_OUTPUT_BITS    = 10,
    parameter int MASTER_OUTPUT_BITS     = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          we,
    input  logic [7:0]                    data,
    input  logic                          pan_we,
    output logic [3:0]                    chan_out,
    output logic [MASTER_OUTPUT_BITS-1:0] audio_left,
    output logic [MASTER_OUTPUT_BITS-1:0] audio_right
);
    localparam int B  = CHANNEL_OUTPUT_BITS;
    localparam int M  = MASTER_OUTPUT_BITS;
    localparam int FB = FREQUENCY_COUNTER_BITS;
    localparam int PW = (CLOCK_DIV > 1) ? $clog2(CLOCK_DIV) : 1;
    localparam logic [LFSR_BITS-1:0] SEED     = {1'b1, {(LFSR_BITS-1){1'b0}}};
    localparam logic [2:0]           TONE_RST = 3'((1 << NUM_TONES) - 1);
    localparam logic [B+1:0]         CLAMP    = (B+2)'((1 << (B+1)) - 1);

    // 10-bit reference table, rescaled to B bits (exact when B=10)
    function automatic logic [B-1:0] vol_of(input logic [3:0] a);
        longint t;
        case (a)
            4'd0:  t = 1023;
            4'd1:  t = 813;
            4'd2:  t = 645;
            4'd3:  t = 513;
            4'd4:  t = 407;
            4'd5:  t = 324;
            4'd6:  t = 257;
            4'd7:  t = 204;
            4'd8:  t = 162;
            4'd9:  t = 129;
            4'd10: t = 102;
            4'd11: t = 81;
            4'd12: t = 65;
            4'd13: t = 51;
            4'd14: t = 41;
            default: t = 0;
        endcase
        return B'((t * ((longint'(1) << B) - 1) + 511) / 1023);
    endfunction

    logic [PW-1:0]        presc;
    logic                 tick;
    logic [3:0]           attn [4];
    logic [FB-1:0]        freq [3];
    logic [FB-1:0]        cnt [3];
    logic [FB-1:0]        cnt_nxt [3];
    logic [2:0]           tone, tone_nxt;
    logic [2:0]           nctrl;
    logic [2:0]           latch;
    logic [7:0]           pan;
    logic [LFSR_BITS-1:0] lfsr, lfsr_sh;
    logic                 noise_out, nsq, nsq_nxt, fb;
    logic [5:0]           ncnt, ncnt_nxt;
    logic                 tone_rise, shift, restart;
    logic                 lat_ok, dat_ok;
    logic [B-1:0]         vol [4];
    logic [B+1:0]         sum_l, sum_r, cl_l, cl_r;

    assign tick     = (presc == PW'(CLOCK_DIV - 1));
    assign chan_out = {noise_out, tone};
    assign restart  = we & data[7] & (data[6:4] == 3'b110);
    // absent tone slots swallow writes; noise (index 3) is always present
    assign lat_ok   = (data[6:5] == 2'b11) || (int'(data[6:5]) < NUM_TONES);
    assign dat_ok   = (latch[2:1] == 2'b11) || (int'(latch[2:1]) < NUM_TONES);

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            tone_nxt[i] = tone[i];
            cnt_nxt[i]  = cnt[i];
            if (i < NUM_TONES && tick) begin
                if (freq[i] <= FB'(1)) begin
                    tone_nxt[i] = 1'b1;
                    cnt_nxt[i]  = '0;
                end else if (cnt[i] == '0) begin
                    cnt_nxt[i]  = freq[i] - FB'(1);
                    tone_nxt[i] = ~tone[i];
                end else begin
                    cnt_nxt[i]  = cnt[i] - FB'(1);
                end
            end
        end
    end

    assign tone_rise = tone_nxt[NUM_TONES-1] & ~tone[NUM_TONES-1];

    always_comb begin
        ncnt_nxt = ncnt;
        nsq_nxt  = nsq;
        if (tick) begin
            if (ncnt == '0) begin
                ncnt_nxt = 6'((7'd16 << nctrl[1:0]) - 7'd1);
                nsq_nxt  = ~nsq;
            end else begin
                ncnt_nxt = ncnt - 6'd1;
            end
        end
    end

    assign shift   = (nctrl[1:0] == 2'b11) ? tone_rise : (nsq_nxt & ~nsq);
    assign fb      = nctrl[2] ? (lfsr[0] ^ lfsr[NOISE_TAP]) : lfsr[0];
    assign lfsr_sh = {fb, lfsr[LFSR_BITS-1:1]};

    always_ff @(posedge clk) begin
        if (reset) begin
            presc <= '0;
            for (int i = 0; i < 4; i++) attn[i] <= 4'hF;
            for (int i = 0; i < 3; i++) begin
                freq[i] <= '0;
                cnt[i]  <= '0;
            end
            tone      <= TONE_RST;
            nctrl     <= 3'b100;
            latch     <= '0;
            pan       <= 8'hFF;
            lfsr      <= SEED;
            noise_out <= 1'b1;
            nsq       <= 1'b1;
            ncnt      <= '0;
        end else begin
            presc <= tick ? '0 : presc + PW'(1);
            tone  <= tone_nxt;
            for (int i = 0; i < 3; i++) cnt[i] <= cnt_nxt[i];
            ncnt  <= ncnt_nxt;
            nsq   <= nsq_nxt;
            // noise output only follows the LFSR once it has been restarted or shifted
            if (restart) begin
                lfsr      <= SEED;
                noise_out <= SEED[0];
                ncnt      <= '0;
                nsq       <= 1'b1;
            end else if (shift) begin
                lfsr      <= lfsr_sh;
                noise_out <= lfsr_sh[0];
            end
            if (we) begin
                if (data[7]) begin
                    latch <= data[6:4];
                    if (data[4]) begin
                        if (lat_ok) attn[data[6:5]] <= data[3:0];
                    end else if (data[6:5] == 2'b11) begin
                        nctrl <= data[2:0];
                    end else if (lat_ok) begin
                        freq[data[6:5]][3:0] <= data[3:0];
                    end
                end else begin
                    if (latch[0]) begin
                        if (dat_ok) attn[latch[2:1]] <= data[3:0];
                    end else if (latch[2:1] != 2'b11 && dat_ok) begin
                        freq[latch[2:1]][FB-1:4] <= data[FB-5:0];
                    end
                end
            end else if (pan_we) begin
                pan <= data;
            end
        end
    end

    always_comb begin
        sum_l = '0;
        sum_r = '0;
        for (int i = 0; i < 4; i++) begin
            vol[i] = chan_out[i] ? vol_of(attn[i]) : '0;
            if (pan[4+i]) sum_l = sum_l + (B+2)'(vol[i]);
            if (pan[i])   sum_r = sum_r + (B+2)'(vol[i]);
        end
        cl_l = (sum_l > CLAMP) ? CLAMP : sum_l;
        cl_r = (sum_r > CLAMP) ? CLAMP : sum_r;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            audio_left  <= '0;
            audio_right <= '0;
        end else begin
            audio_left  <= cl_l[B -: M];
            audio_right <= cl_r[B -: M];
        end
    end
endmodule

// File: tb/tb_psg_stereo_core.sv
// Directed bench for psg_stereo_core: tone timing, mixer clamp, pan, noise LFSR, write corner cases.
module tb_psg_stereo_core;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       we0 = 1'b0, pan_we0 = 1'b0, we1 = 1'b0, pan_we1 = 1'b0;
    logic [7:0] data0 = 8'h00, data1 = 8'h00;
    logic [3:0] co0, co1;
    logic [7:0] al0, ar0, al1, ar1;
    int         total = 0;
    int         bad = 0;

    psg_stereo_core u0 (
        .clk(clk), .reset(reset), .we(we0), .data(data0), .pan_we(pan_we0),
        .chan_out(co0), .audio_left(al0), .audio_right(ar0)
    );

    psg_stereo_core #(.NUM_TONES(1)) u1 (
        .clk(clk), .reset(reset), .we(we1), .data(data1), .pan_we(pan_we1),
        .chan_out(co1), .audio_left(al1), .audio_right(ar1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    task automatic wr0(input logic [7:0] b);
        @(negedge clk); we0 = 1'b1; data0 = b;
        @(negedge clk); we0 = 1'b0;
    endtask

    task automatic wr1(input logic [7:0] b);
        @(negedge clk); we1 = 1'b1; data1 = b;
        @(negedge clk); we1 = 1'b0;
    endtask

    function automatic logic [31:0] mixv(input int n);
        int s;
        s = n * 1023;
        if (s > 2047) s = 2047;
        return 32'(s >> 3);
    endfunction

    function automatic logic [31:0] half(input logic on);
        return on ? 32'd127 : 32'd0;
    endfunction

    initial begin
        logic        p, p1, p2, white, fbit;
        logic [2:0]  p3;
        logic [14:0] m;
        int          last, ntog, n, shifts, cyc, nexp;
        bit          seen;

        repeat (3) @(negedge clk);
        reset = 1'b0;

        // idle after reset
        for (int k = 0; k < 100; k++) begin
            @(posedge clk); #1;
            chk("rst_chan", 32'(co0), 32'hF);
            chk("rst_left", 32'(al0), 0);
            chk("rst_right", 32'(ar0), 0);
        end
        chk("rst_chan_1tone", 32'(co1), 32'b1001);

        // tone0 freq 5, attn 0: 80-clk half period, 127 on both sides while high
        wr0(8'h85); wr0(8'h00); wr0(8'h90);
        p = co0[0]; last = -1; ntog = 0;
        for (int k = 0; k < 400; k++) begin
            @(posedge clk); #1;
            chk("t0_left", 32'(al0), half(p));
            chk("t0_right", 32'(ar0), half(p));
            if (co0[0] !== p) begin
                if (last >= 0) chk("t0_period", 32'(k - last), 80);
                last = k; ntog++;
            end
            p = co0[0];
        end
        chk("t0_toggles", 32'(ntog >= 4), 1);

        // reset mid-tone with a pan strobe that must be ignored
        @(negedge clk); reset = 1'b1; pan_we0 = 1'b1; data0 = 8'h00;
        @(negedge clk); reset = 1'b0; pan_we0 = 1'b0;
        chk("midrst_chan", 32'(co0), 32'hF);
        chk("midrst_left", 32'(al0), 0);
        chk("midrst_right", 32'(ar0), 0);

        // three tones at attn 0: sum clamps to 255
        wr0(8'h82); wr0(8'hA2); wr0(8'hC1);
        wr0(8'h90); wr0(8'hB0); wr0(8'hD0);
        p3 = co0[2:0]; seen = 0;
        for (int k = 0; k < 300; k++) begin
            @(posedge clk); #1;
            n = int'(p3[0]) + int'(p3[1]) + int'(p3[2]);
            if (n == 3) seen = 1;
            chk("mix_left", 32'(al0), mixv(n));
            chk("mix_right", 32'(ar0), mixv(n));
            p3 = co0[2:0];
        end
        chk("mix_all_high_seen", 32'(seen), 1);

        // pan 1E: left ch0 only, right ch3..1; only tone0 audible
        @(negedge clk); pan_we0 = 1'b1; data0 = 8'h1E;
        @(negedge clk); pan_we0 = 1'b0;
        wr0(8'hBF); wr0(8'hDF);
        p = co0[0];
        for (int k = 0; k < 200; k++) begin
            @(posedge clk); #1;
            chk("pan_left", 32'(al0), half(p));
            chk("pan_right", 32'(ar0), 0);
            p = co0[0];
        end

        // we and pan_we together: attn1=0 applies, pan stays 1E
        @(negedge clk); we0 = 1'b1; pan_we0 = 1'b1; data0 = 8'hB0;
        @(negedge clk); we0 = 1'b0; pan_we0 = 1'b0;
        p = co0[0]; p1 = co0[1];
        for (int k = 0; k < 200; k++) begin
            @(posedge clk); #1;
            chk("both_left", 32'(al0), half(p));
            chk("both_right", 32'(ar0), half(p1));
            p = co0[0]; p1 = co0[1];
        end

        // white noise at rate 16: output first rises on shift 14
        wr0(8'hE4);
        chk("noise_seed", 32'(co0[3]), 0);
        n = 8001;
        for (int k = 1; k <= 8000; k++) begin
            @(posedge clk); #1;
            if (co0[3]) begin n = k; break; end
        end
        chk("noise_first_one", 32'(n >= 6913 && n <= 6928), 1);
        wr0(8'hF0);

        // noise clocked by tone2 rising edges: periodic, then white
        wr0(8'hC2);
        for (int pass = 0; pass < 2; pass++) begin
            white = (pass == 1);
            nexp  = white ? 200 : 45;
            wr0(white ? 8'hE7 : 8'hE3);
            m = 15'h4000; p2 = co0[2]; shifts = 0; cyc = 0;
            chk("noise_restart", 32'(co0[3]), 0);
            while (shifts < nexp && cyc < 20000) begin
                @(posedge clk); #1;
                cyc++;
                if (co0[2] && !p2) begin
                    fbit = white ? (m[0] ^ m[1]) : m[0];
                    m = {fbit, m[14:1]};
                    shifts++;
                end
                chk(white ? "noise_white" : "noise_periodic", 32'(co0[3]), 32'(m[0]));
                p2 = co0[2];
            end
            chk("noise_shift_count", 32'(shifts), 32'(nexp));
        end

        // single-tone build: absent-tone writes dropped but latch still moves
        wr1(8'h85); wr1(8'h00); wr1(8'h90); wr1(8'hA6); wr1(8'h01);
        p = co1[0]; last = -1; ntog = 0;
        for (int k = 0; k < 600; k++) begin
            @(posedge clk); #1;
            chk("one_absent", 32'(co1[2:1]), 0);
            chk("one_left", 32'(al1), half(p));
            if (co1[0] !== p) begin
                if (last >= 0) chk("one_period", 32'(k - last), 80);
                last = k; ntog++;
            end
            p = co1[0];
        end
        chk("one_toggles", 32'(ntog >= 6), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
